// File: rtl/usb_pkg.sv
// Shared definitions for the USB serial packet encoder: PID codes, encoder
// states, packet classes, field lengths and CRC polynomials.
package usb_pkg;

    // PID nibbles as they appear on the pid input.
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    // CRC generators, written MSB-first without the implicit top term.
    localparam logic [4:0]  CRC5_POLY  = 5'b00101;
    localparam logic [4:0]  CRC5_INIT  = 5'b11111;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Field lengths in bits.
    localparam logic [6:0] LEN_SYNC  = 7'd8;
    localparam logic [6:0] LEN_PID   = 7'd8;
    localparam logic [6:0] LEN_TOKEN = 7'd11;
    localparam logic [6:0] LEN_CRC5  = 7'd5;
    localparam logic [6:0] LEN_DATA  = 7'd64;
    localparam logic [6:0] LEN_CRC16 = 7'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOKEN,
        ST_CRC5,
        ST_DATA,
        ST_CRC16,
        ST_DONE
    } enc_state_t;

    // What follows the PID field.
    typedef enum logic [1:0] {
        PK_HANDSHAKE,
        PK_TOKEN,
        PK_DATA
    } pkt_kind_t;

    // True for the PIDs this encoder knows how to send.
    function automatic logic pid_supported(logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK: pid_supported = 1'b1;
            default:                                                 pid_supported = 1'b0;
        endcase
    endfunction

    // Packet class of a PID; only meaningful for supported PIDs.
    function automatic pkt_kind_t pid_kind(logic [3:0] p);
        case (p)
            PID_OUT, PID_IN:       pid_kind = PK_TOKEN;
            PID_DATA0, PID_DATA1:  pid_kind = PK_DATA;
            default:               pid_kind = PK_HANDSHAKE;
        endcase
    endfunction

    // Number of bits in the field sent from a given state.
    function automatic logic [6:0] field_len(enc_state_t s);
        case (s)
            ST_SYNC:  field_len = LEN_SYNC;
            ST_PID:   field_len = LEN_PID;
            ST_TOKEN: field_len = LEN_TOKEN;
            ST_CRC5:  field_len = LEN_CRC5;
            ST_DATA:  field_len = LEN_DATA;
            ST_CRC16: field_len = LEN_CRC16;
            default:  field_len = 7'd1;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc_ser.sv
// Bit-serial CRC shift register. One input bit per enabled cycle, MSB-first
// remainder convention: feedback is din xor the current top bit.
module usb_crc_ser #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);

    logic             feedback;
    logic [WIDTH-1:0] crc_next;

    // Next remainder after shifting in one bit.
    always_comb begin
        feedback = din ^ crc[WIDTH-1];
        crc_next = {crc[WIDTH-2:0], 1'b0} ^ (feedback ? POLY : '0);
    end

    // Remainder register: preset on reset or clear, advanced when enabled.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            crc <= INIT;
        end else if (clr) begin
            crc <= INIT;
        end else if (en) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/usb_encoder.sv
// USB packet encoder: latches one packet request and serialises
// SYNC, PID, token/data payload and CRC onto bstr, honouring bstr_pause.
module usb_encoder (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        pkt_avail,
    input  logic [3:0]  pid,
    input  logic [6:0]  addr,
    input  logic [3:0]  endp,
    input  logic [63:0] data,
    input  logic        bstr_pause,
    output logic        enc_ready,
    output logic        bstr,
    output logic        bstr_avail,
    output logic        bstr_done,
    output logic        pid_err
);

    import usb_pkg::*;

    enc_state_t  state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    pkt_kind_t   kind_q;
    logic [3:0]  pid_q;
    logic [10:0] tok_q;
    logic [63:0] data_q;
    logic        pid_err_q;

    logic        accept;
    logic        active;
    logic        step;
    logic        last_bit;
    logic        bit_sel;
    logic [2:0]  crc5_idx;
    logic [3:0]  crc16_idx;
    logic        crc5_en;
    logic        crc16_en;
    logic [4:0]  crc5;
    logic [15:0] crc16;

    // Handshake and per-cycle control derived from the current state.
    always_comb begin
        accept    = (state_q == ST_IDLE) && pkt_avail;
        active    = (state_q != ST_IDLE) && (state_q != ST_DONE);
        step      = active && !bstr_pause;
        last_bit  = (cnt_q == field_len(state_q) - 7'd1);
        crc5_idx  = 3'd4 - cnt_q[2:0];
        crc16_idx = 4'd15 - cnt_q[3:0];
        crc5_en   = step && (state_q == ST_TOKEN);
        crc16_en  = step && (state_q == ST_DATA);
    end

    // Select the bit for the current state and counter; zero when idle.
    always_comb begin
        bit_sel = 1'b0;
        case (state_q)
            ST_SYNC:  bit_sel = (cnt_q == 7'd7);
            ST_PID:   bit_sel = pid_q[cnt_q[1:0]] ^ cnt_q[2];
            ST_TOKEN: bit_sel = tok_q[cnt_q[3:0]];
            ST_CRC5:  bit_sel = ~crc5[crc5_idx];
            ST_DATA:  bit_sel = data_q[cnt_q[5:0]];
            ST_CRC16: bit_sel = ~crc16[crc16_idx];
            default:  bit_sel = 1'b0;
        endcase
    end

    // Field sequencing and bit counter; frozen while paused.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && pid_supported(pid)) begin
                    state_d = ST_SYNC;
                    cnt_d   = 7'd0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 7'd0;
            end
            default: begin
                if (step) begin
                    if (last_bit) begin
                        cnt_d = 7'd0;
                        case (state_q)
                            ST_SYNC:  state_d = ST_PID;
                            ST_PID: begin
                                case (kind_q)
                                    PK_TOKEN: state_d = ST_TOKEN;
                                    PK_DATA:  state_d = ST_DATA;
                                    default:  state_d = ST_DONE;
                                endcase
                            end
                            ST_TOKEN: state_d = ST_CRC5;
                            ST_DATA:  state_d = ST_CRC16;
                            default:  state_d = ST_DONE;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
        endcase
    end

    // State, counter and error-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 7'd0;
            pid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pid_err_q <= accept && !pid_supported(pid);
        end
    end

    // Packet fields captured at accept and held for the whole packet.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; they are always written at
        // accept before any state reads them, so reset would only cost logic.
        if (accept) begin
            pid_q  <= pid;
            kind_q <= pid_kind(pid);
            tok_q  <= {endp, addr};
            data_q <= data;
        end
    end

    usb_crc_ser #(
        .WIDTH (5),
        .POLY  (CRC5_POLY),
        .INIT  (CRC5_INIT)
    ) u_crc5 (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (accept),
        .en    (crc5_en),
        .din   (bit_sel),
        .crc   (crc5)
    );

    usb_crc_ser #(
        .WIDTH (16),
        .POLY  (CRC16_POLY),
        .INIT  (CRC16_INIT)
    ) u_crc16 (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (accept),
        .en    (crc16_en),
        .din   (bit_sel),
        .crc   (crc16)
    );

    // Output drive: bits only in active states and only when not paused.
    always_comb begin
        enc_ready  = (state_q == ST_IDLE);
        bstr       = bit_sel;
        bstr_avail = step;
        bstr_done  = (state_q == ST_DONE);
        pid_err    = pid_err_q;
    end

endmodule

// File: tb/tb_usb_encoder.sv
// Directed bench for usb_encoder: handshake, token and data packets,
// backpressure, PID rejection and reset abort.
module tb_usb_encoder;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        pkt_avail;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        bstr_pause;
    logic        enc_ready;
    logic        bstr;
    logic        bstr_avail;
    logic        bstr_done;
    logic        pid_err;

    int total = 0;
    int bad   = 0;

    usb_encoder dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .pkt_avail  (pkt_avail),
        .pid        (pid),
        .addr       (addr),
        .endp       (endp),
        .data       (data),
        .bstr_pause (bstr_pause),
        .enc_ready  (enc_ready),
        .bstr       (bstr),
        .bstr_avail (bstr_avail),
        .bstr_done  (bstr_done),
        .pid_err    (pid_err)
    );

    always #5 clk = ~clk;

    // Receiver-side CRC models, one bit at a time.
    function automatic logic [4:0] crc5_feed(logic [4:0] c, logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [15:0] crc16_feed(logic [15:0] c, logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // Send one packet and capture the serial stream; pause is raised for
    // pause_len cycles starting pause_cyc cycles after accept.
    task automatic send_pkt(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                            input logic [63:0] d, input int pause_cyc, input int pause_len,
                            output logic [127:0] bits, output int nbits, output int done_cnt,
                            output int paused_avail, output int busy_ready,
                            output logic ready_after, output logic done_after);
        bits = '0; nbits = 0; done_cnt = 0; paused_avail = 0; busy_ready = 0;
        @(posedge clk); #1;
        pkt_avail = 1'b1; pid = p; addr = a; endp = e; data = d;
        @(posedge clk); #1;
        pkt_avail = 1'b1; pid = 4'b0111; addr = '1; endp = '1; data = '1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            bstr_pause = (cyc >= pause_cyc) && (cyc < pause_cyc + pause_len);
            @(negedge clk);
            if (enc_ready) busy_ready++;
            if (bstr_avail) begin
                if (bstr_pause) paused_avail++;
                if (nbits < 128) bits[nbits] = bstr;
                nbits++;
            end
            if (bstr_done) begin
                done_cnt++;
                break;
            end
            @(posedge clk); #1;
        end
        pkt_avail = 1'b0;
        bstr_pause = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        ready_after = enc_ready;
        done_after  = bstr_done;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; pkt_avail = 1'b0; pid = '0; addr = '0; endp = '0; data = '0;
        bstr_pause = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        total++; if (enc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", enc_ready); end
        total++; if (bstr_avail !== 1'b0) begin bad++; $display("FAIL reset_avail got=%b want=0", bstr_avail); end
        total++; if (bstr !== 1'b0) begin bad++; $display("FAIL reset_bstr got=%b want=0", bstr); end
        total++; if (bstr_done !== 1'b0 || pid_err !== 1'b0) begin bad++;
            $display("FAIL reset_pulses got done=%b err=%b want 0 0", bstr_done, pid_err); end
    endtask

    task automatic test_ack(input string tag, input int pause_cyc, input int pause_len);
        logic [127:0] bits; int nbits, done_cnt, paused_avail, busy_ready;
        logic ready_after, done_after;
        logic [15:0] want, got;
        want = 16'b0000000101001011;
        send_pkt(4'b0010, 7'd0, 4'd0, 64'd0, pause_cyc, pause_len,
                 bits, nbits, done_cnt, paused_avail, busy_ready, ready_after, done_after);
        for (int i = 0; i < 16; i++) got[15-i] = bits[i];
        total++; if (nbits !== 16) begin bad++; $display("FAIL %s_count got=%0d want=16", tag, nbits); end
        total++; if (got !== want) begin bad++; $display("FAIL %s_bits got=%b want=%b", tag, got, want); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL %s_done got=%0d want=1", tag, done_cnt); end
        total++; if (ready_after !== 1'b1 || done_after !== 1'b0) begin bad++;
            $display("FAIL %s_after_done got ready=%b done=%b want 1 0", tag, ready_after, done_after); end
        total++; if (busy_ready !== 0) begin bad++; $display("FAIL %s_busy_ready got=%0d want=0", tag, busy_ready); end
        if (pause_len > 0) begin
            total++; if (paused_avail !== 0) begin bad++;
                $display("FAIL %s_paused_avail got=%0d want=0", tag, paused_avail); end
        end
    endtask

    task automatic test_token_out();
        logic [127:0] bits; int nbits, done_cnt, paused_avail, busy_ready;
        logic ready_after, done_after;
        logic [4:0] last5;
        send_pkt(4'b0001, 7'd0, 4'd0, 64'd0, 1000, 0,
                 bits, nbits, done_cnt, paused_avail, busy_ready, ready_after, done_after);
        last5 = {bits[27], bits[28], bits[29], bits[30], bits[31]};
        total++; if (nbits !== 32) begin bad++; $display("FAIL out_count got=%0d want=32", nbits); end
        total++; if (last5 !== 5'b01000) begin bad++; $display("FAIL out_crc5 got=%b want=01000", last5); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL out_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_token_in();
        logic [127:0] bits; int nbits, done_cnt, paused_avail, busy_ready;
        logic ready_after, done_after;
        logic [26:0] want, got;
        logic [4:0] res;
        // SYNC, PID 1001 -> 1001 0110, addr 0x15 LSB first, endp 0xE LSB first.
        want = 27'b00000001_10010110_1010100_0111;
        send_pkt(4'b1001, 7'h15, 4'hE, 64'd0, 1000, 0,
                 bits, nbits, done_cnt, paused_avail, busy_ready, ready_after, done_after);
        for (int i = 0; i < 27; i++) got[26-i] = bits[i];
        res = 5'b11111;
        for (int i = 16; i < 32; i++) res = crc5_feed(res, bits[i]);
        total++; if (nbits !== 32) begin bad++; $display("FAIL in_count got=%0d want=32", nbits); end
        total++; if (got !== want) begin bad++; $display("FAIL in_fields got=%b want=%b", got, want); end
        total++; if (res !== 5'b01100) begin bad++; $display("FAIL in_crc5_residual got=%b want=01100", res); end
    endtask

    task automatic test_data0();
        logic [127:0] bits; int nbits, done_cnt, paused_avail, busy_ready;
        logic ready_after, done_after;
        logic [63:0] d, got_d;
        logic [15:0] hdr_want, hdr_got, res;
        d = 64'h0807060504030201;
        hdr_want = 16'b0000000111000011;
        send_pkt(4'b0011, 7'd0, 4'd0, d, 1000, 0,
                 bits, nbits, done_cnt, paused_avail, busy_ready, ready_after, done_after);
        for (int i = 0; i < 16; i++) hdr_got[15-i] = bits[i];
        for (int i = 0; i < 64; i++) got_d[i] = bits[16+i];
        res = 16'hFFFF;
        for (int i = 16; i < 96; i++) res = crc16_feed(res, bits[i]);
        total++; if (nbits !== 96) begin bad++; $display("FAIL data0_count got=%0d want=96", nbits); end
        total++; if (hdr_got !== hdr_want) begin bad++; $display("FAIL data0_hdr got=%b want=%b", hdr_got, hdr_want); end
        total++; if (got_d !== d) begin bad++; $display("FAIL data0_payload got=%h want=%h", got_d, d); end
        total++; if (res !== 16'h800D) begin bad++; $display("FAIL data0_crc16_residual got=%h want=800d", res); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL data0_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_pid_err();
        @(posedge clk); #1;
        pkt_avail = 1'b1; pid = 4'b0111;
        @(posedge clk); #1;
        pkt_avail = 1'b0; pid = 4'b0000;
        @(negedge clk);
        total++; if (pid_err !== 1'b1) begin bad++; $display("FAIL piderr_pulse got=%b want=1", pid_err); end
        total++; if (enc_ready !== 1'b1 || bstr_avail !== 1'b0) begin bad++;
            $display("FAIL piderr_idle got ready=%b avail=%b want 1 0", enc_ready, bstr_avail); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (pid_err !== 1'b0 || bstr_avail !== 1'b0) begin bad++;
            $display("FAIL piderr_one_cycle got err=%b avail=%b want 0 0", pid_err, bstr_avail); end
    endtask

    task automatic test_reset_abort();
        int nbits = 0;
        int done_cnt = 0;
        @(posedge clk); #1;
        pkt_avail = 1'b1; pid = 4'b0011; data = 64'hA5A5_5A5A_F00F_0FF0;
        @(posedge clk); #1;
        pkt_avail = 1'b0;
        // With no pause, cycle 56 after accept carries DATA bit 40.
        for (int cyc = 0; cyc <= 56; cyc++) begin
            if (cyc == 56) rst_b = 1'b0;
            @(negedge clk);
            if (bstr_avail) nbits++;
            if (bstr_done) done_cnt++;
            @(posedge clk); #1;
        end
        rst_b = 1'b1;
        @(negedge clk);
        total++; if (nbits !== 57) begin bad++; $display("FAIL abort_bits_before got=%0d want=57", nbits); end
        total++; if (enc_ready !== 1'b1 || bstr_avail !== 1'b0) begin bad++;
            $display("FAIL abort_idle got ready=%b avail=%b want 1 0", enc_ready, bstr_avail); end
        for (int i = 0; i < 6; i++) begin
            if (bstr_done) done_cnt++;
            @(negedge clk);
        end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_ack("ack", 1000, 0);
        test_token_out();
        test_token_in();
        test_data0();
        test_ack("pause", 10, 3);
        test_pid_err();
        test_reset_abort();
        test_ack("ack_after_abort", 1000, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
